// File: rtl/wave_buf_ctrl_if.sv
// Sample stream and capture-RAM write port shared by the waveform buffer
// controller and whatever feeds it (ADC front end / testbench).
interface wave_buf_ctrl_if;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic        wr_en;
  logic [10:0] wr_addr;
  logic [7:0]  wr_data;

  // Sample source side: offers samples, observes the RAM write port
  modport master (
    output s_data, s_valid,
    input  s_ready, wr_en, wr_addr, wr_data
  );

  // Controller side: accepts samples, drives the RAM write port
  modport slave (
    input  s_data, s_valid,
    output s_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/wave_buf_ctrl.sv
// Double-buffered oscilloscope trace controller. Samples are captured into
// the bank not on screen; once a full trace is held, the banks swap at the
// next frame start so the display never shows a half-written trace.
module wave_buf_ctrl #(
  parameter logic [10:0] PLOT_W      = 11'd1000,
  parameter logic [10:0] X0          = 11'd140,
  parameter logic [7:0]  TRIG_LEVEL  = 8'd128,
  parameter logic [15:0] ARM_TIMEOUT = 16'd4096
) (
  input  logic          pixel_clk,
  input  logic          sys_rst,
  input  logic          frame_start,
  input  logic          trig_en,
  input  logic [10:0]   pixel_xpos,
  output logic [10:0]   rd_addr,
  output logic          rd_valid,
  output logic          disp_bank,
  output logic          busy,
  output logic [15:0]   swap_cnt,
  wave_buf_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ARM     = 2'd0,
    CAPTURE = 2'd1,
    HOLD    = 2'd2
  } state_t;

  localparam logic [9:0]  LAST_IDX = 10'(PLOT_W - 11'd1);
  localparam logic [11:0] X_END    = {1'b0, X0} + {1'b0, PLOT_W};

  state_t      state_q, state_d;
  logic [9:0]  index_q, index_d;
  logic [15:0] arm_cnt_q, arm_cnt_d;
  logic [7:0]  prev_q, prev_d;
  logic        disp_bank_q, disp_bank_d;
  logic [15:0] swap_cnt_q, swap_cnt_d;
  logic        rd_valid_d, rd_valid_q;
  logic [10:0] rd_addr_d, rd_addr_q;

  logic        ready;
  logic        accept;
  logic        do_write;
  logic [9:0]  wr_index;
  logic        level_hit;
  logic        timeout_hit;
  logic        in_plot;

  // Next-state, capture bookkeeping, write port and read-side address mapping
  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    arm_cnt_d   = arm_cnt_q;
    prev_d      = prev_q;
    disp_bank_d = disp_bank_q;
    swap_cnt_d  = swap_cnt_q;
    do_write    = 1'b0;
    wr_index    = index_q;

    ready       = !sys_rst && (state_q != HOLD);
    accept      = bus.s_valid && ready;
    level_hit   = (prev_q < TRIG_LEVEL) && (bus.s_data >= TRIG_LEVEL);
    timeout_hit = (arm_cnt_q == ARM_TIMEOUT - 16'd1);

    case (state_q)
      ARM: begin
        if (accept) begin
          prev_d    = bus.s_data;
          arm_cnt_d = arm_cnt_q + 16'd1;
          if (!trig_en || level_hit || timeout_hit) begin
            do_write = 1'b1;
            wr_index = 10'd0;
            index_d  = 10'd1;
            state_d  = CAPTURE;
          end
        end
      end
      CAPTURE: begin
        if (accept) begin
          do_write = 1'b1;
          if (index_q == LAST_IDX) begin
            state_d = HOLD;
          end else begin
            index_d = index_q + 10'd1;
          end
        end
      end
      HOLD: begin
        if (frame_start) begin
          disp_bank_d = ~disp_bank_q;
          swap_cnt_d  = swap_cnt_q + 16'd1;
          index_d     = 10'd0;
          arm_cnt_d   = 16'd0;
          prev_d      = 8'hFF;
          state_d     = ARM;
        end
      end
      default: begin
        state_d = ARM;
      end
    endcase

    in_plot    = (pixel_xpos >= X0) && ({1'b0, pixel_xpos} < X_END);
    rd_valid_d = in_plot;
    rd_addr_d  = in_plot ? {disp_bank_q, 10'(pixel_xpos - X0)} : 11'd0;
  end

  // State and bookkeeping registers with synchronous reset
  always_ff @(posedge pixel_clk) begin
    if (sys_rst) begin
      state_q     <= ARM;
      index_q     <= 10'd0;
      arm_cnt_q   <= 16'd0;
      prev_q      <= 8'hFF;
      disp_bank_q <= 1'b0;
      swap_cnt_q  <= 16'd0;
      rd_valid_q  <= 1'b0;
      rd_addr_q   <= 11'd0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      arm_cnt_q   <= arm_cnt_d;
      prev_q      <= prev_d;
      disp_bank_q <= disp_bank_d;
      swap_cnt_q  <= swap_cnt_d;
      rd_valid_q  <= rd_valid_d;
      rd_addr_q   <= rd_addr_d;
    end
  end

  assign bus.s_ready = ready;
  assign bus.wr_en   = do_write;
  assign bus.wr_addr = {~disp_bank_q, wr_index};
  assign bus.wr_data = bus.s_data;

  assign rd_valid  = rd_valid_q;
  assign rd_addr   = rd_addr_q;
  assign disp_bank = disp_bank_q;
  assign swap_cnt  = swap_cnt_q;
  assign busy      = (state_q != HOLD);

endmodule

// File: tb/tb_wave_buf_ctrl.sv
// Directed bench for wave_buf_ctrl: free-run fill, read mapping, bank swap,
// level trigger, deferred swap, auto-trigger and mid-capture reset.
module tb_wave_buf_ctrl;

  logic        pixel_clk = 1'b0;
  logic        sys_rst;
  logic        frame_start;
  logic        trig_en;
  logic [10:0] pixel_xpos;
  logic [10:0] rd_addr;
  logic        rd_valid;
  logic        disp_bank;
  logic        busy;
  logic [15:0] swap_cnt;

  int numChecks = 0;
  int numFails  = 0;

  wave_buf_ctrl_if ifc ();

  wave_buf_ctrl dut (
    .pixel_clk   (pixel_clk),
    .sys_rst     (sys_rst),
    .frame_start (frame_start),
    .trig_en     (trig_en),
    .pixel_xpos  (pixel_xpos),
    .rd_addr     (rd_addr),
    .rd_valid    (rd_valid),
    .disp_bank   (disp_bank),
    .busy        (busy),
    .swap_cnt    (swap_cnt),
    .bus         (ifc.slave)
  );

  // 100 MHz pixel clock
  always #5 pixel_clk = ~pixel_clk;

  // Advance one clock and settle just after the edge
  task automatic applyStimulus();
    @(posedge pixel_clk);
    #1;
  endtask

  // One counted comparison
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    numChecks++;
    assert (observed === expected)
    else begin
      numFails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Hard time limit so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence
  initial begin
    int wrCount;
    int wrBad;

    sys_rst     = 1'b1;
    frame_start = 1'b0;
    trig_en     = 1'b0;
    pixel_xpos  = 11'd0;
    ifc.s_valid = 1'b1;
    ifc.s_data  = 8'h55;

    // Reset: no accept and no write while reset is high
    applyStimulus();
    applyStimulus();
    checkOutput("rst_s_ready", 32'(ifc.s_ready), 32'd0);
    checkOutput("rst_wr_en", 32'(ifc.wr_en), 32'd0);
    checkOutput("rst_rd_valid", 32'(rd_valid), 32'd0);
    checkOutput("rst_rd_addr", 32'(rd_addr), 32'd0);
    checkOutput("rst_disp_bank", 32'(disp_bank), 32'd0);
    checkOutput("rst_swap_cnt", 32'(swap_cnt), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd1);

    // Free-run fill of bank 1: every sample written in order
    sys_rst = 1'b0;
    wrBad = 0;
    for (int i = 0; i < 1000; i++) begin
      ifc.s_valid = 1'b1;
      ifc.s_data  = 8'(i * 3);
      #1;
      if (!(ifc.wr_en === 1'b1 && ifc.wr_addr === 11'(11'h400 + i) && ifc.wr_data === 8'(i * 3)))
        wrBad++;
      if (i == 0) checkOutput("free_first_addr", 32'(ifc.wr_addr), 32'h400);
      if (i == 999) checkOutput("free_last_addr", 32'(ifc.wr_addr), 32'h7E7);
      applyStimulus();
    end
    checkOutput("free_fill_sequence_errors", 32'(wrBad), 32'd0);
    #1;
    checkOutput("hold_s_ready", 32'(ifc.s_ready), 32'd0);
    checkOutput("hold_busy", 32'(busy), 32'd0);
    checkOutput("hold_no_write", 32'(ifc.wr_en), 32'd0);

    // Read mapping around the plot edges, one cycle latency
    pixel_xpos = 11'd139;
    applyStimulus();
    checkOutput("rd_139_valid", 32'(rd_valid), 32'd0);
    checkOutput("rd_139_addr", 32'(rd_addr), 32'd0);
    pixel_xpos = 11'd140;
    applyStimulus();
    checkOutput("rd_140_valid", 32'(rd_valid), 32'd1);
    checkOutput("rd_140_addr", 32'(rd_addr), 32'h000);
    pixel_xpos = 11'd1139;
    applyStimulus();
    checkOutput("rd_1139_valid", 32'(rd_valid), 32'd1);
    checkOutput("rd_1139_addr", 32'(rd_addr), 32'd999);
    pixel_xpos = 11'd1140;
    applyStimulus();
    checkOutput("rd_1140_valid", 32'(rd_valid), 32'd0);
    checkOutput("rd_1140_addr", 32'(rd_addr), 32'd0);

    // Swap on frame start while holding
    ifc.s_valid = 1'b0;
    frame_start = 1'b1;
    applyStimulus();
    frame_start = 1'b0;
    checkOutput("swap1_disp_bank", 32'(disp_bank), 32'd1);
    checkOutput("swap1_swap_cnt", 32'(swap_cnt), 32'd1);
    checkOutput("swap1_busy", 32'(busy), 32'd1);
    pixel_xpos = 11'd1139;
    applyStimulus();
    checkOutput("rd_bank1_addr", 32'(rd_addr), 32'h7E7);

    // Level trigger on rising crossing of 128; frame start ignored in ARM
    trig_en     = 1'b1;
    ifc.s_valid = 1'b1;
    ifc.s_data  = 8'd10;
    frame_start = 1'b1;
    #1;
    checkOutput("lvl_10_no_write", 32'(ifc.wr_en), 32'd0);
    applyStimulus();
    frame_start = 1'b0;
    checkOutput("arm_ignores_frame_start", 32'(disp_bank), 32'd1);
    ifc.s_data = 8'd50;
    #1;
    checkOutput("lvl_50_no_write", 32'(ifc.wr_en), 32'd0);
    applyStimulus();
    ifc.s_data = 8'd127;
    #1;
    checkOutput("lvl_127_no_write", 32'(ifc.wr_en), 32'd0);
    applyStimulus();
    ifc.s_data = 8'd128;
    #1;
    checkOutput("lvl_128_wr_en", 32'(ifc.wr_en), 32'd1);
    checkOutput("lvl_128_wr_addr", 32'(ifc.wr_addr), 32'h000);
    checkOutput("lvl_128_wr_data", 32'(ifc.wr_data), 32'd128);
    applyStimulus();
    ifc.s_data = 8'd200;
    #1;
    checkOutput("lvl_200_wr_addr", 32'(ifc.wr_addr), 32'h001);
    applyStimulus();

    // Finish capture into bank 0; frame start on the last write is deferred
    for (int i = 2; i < 1000; i++) begin
      ifc.s_data  = 8'(i);
      frame_start = (i == 999);
      if (i == 999) begin
        #1;
        checkOutput("last_write_addr", 32'(ifc.wr_addr), 32'h3E7);
      end
      applyStimulus();
    end
    frame_start = 1'b0;
    checkOutput("defer_busy", 32'(busy), 32'd0);
    checkOutput("defer_disp_bank", 32'(disp_bank), 32'd1);
    checkOutput("defer_swap_cnt", 32'(swap_cnt), 32'd1);
    applyStimulus();
    checkOutput("defer_still_bank1", 32'(disp_bank), 32'd1);
    frame_start = 1'b1;
    applyStimulus();
    frame_start = 1'b0;
    checkOutput("swap2_disp_bank", 32'(disp_bank), 32'd0);
    checkOutput("swap2_swap_cnt", 32'(swap_cnt), 32'd2);

    // Auto-trigger: flat zero input fires on the 4096th accepted sample
    ifc.s_data = 8'd0;
    wrCount = 0;
    for (int i = 1; i < 4096; i++) begin
      #1;
      if (ifc.wr_en === 1'b1) wrCount++;
      applyStimulus();
    end
    checkOutput("auto_no_early_write", 32'(wrCount), 32'd0);
    #1;
    checkOutput("auto_wr_en", 32'(ifc.wr_en), 32'd1);
    checkOutput("auto_wr_addr", 32'(ifc.wr_addr), 32'h400);
    applyStimulus();

    // Capture up to index 500, then reset mid-trace
    for (int i = 1; i < 500; i++) begin
      ifc.s_data = 8'(i);
      applyStimulus();
    end
    #1;
    checkOutput("pre_rst_wr_addr", 32'(ifc.wr_addr), 32'h5F4);
    sys_rst = 1'b1;
    #1;
    checkOutput("mid_rst_wr_en", 32'(ifc.wr_en), 32'd0);
    checkOutput("mid_rst_s_ready", 32'(ifc.s_ready), 32'd0);
    applyStimulus();
    sys_rst = 1'b0;
    checkOutput("post_rst_busy", 32'(busy), 32'd1);
    checkOutput("post_rst_disp_bank", 32'(disp_bank), 32'd0);
    checkOutput("post_rst_swap_cnt", 32'(swap_cnt), 32'd0);

    // Back in ARM with prev cleared: first high sample must not trigger
    ifc.s_data = 8'd200;
    #1;
    checkOutput("post_rst_s_ready", 32'(ifc.s_ready), 32'd1);
    checkOutput("post_rst_first_no_trig", 32'(ifc.wr_en), 32'd0);
    applyStimulus();
    ifc.s_data = 8'd0;
    applyStimulus();
    ifc.s_data = 8'd200;
    #1;
    checkOutput("post_rst_trig_wr_en", 32'(ifc.wr_en), 32'd1);
    checkOutput("post_rst_trig_addr", 32'(ifc.wr_addr), 32'h400);
    applyStimulus();
    ifc.s_valid = 1'b0;
    applyStimulus();

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule

// File: doc/wave_buf_ctrl.md
WAVE_BUF_CTRL -- requirements
Module: wave_buf_ctrl

Interface
REQ-001 SHALL have parameter PLOT_W, default 11'd1000, meaning samples per trace and plot width in pixels.
REQ-002 SHALL have parameter X0, default 11'd140, meaning the first plot column in pixel_xpos.
REQ-003 SHALL have parameter TRIG_LEVEL, default 8'd128, meaning the rising-edge trigger threshold.
REQ-004 SHALL have parameter ARM_TIMEOUT, default 16'd4096, meaning accepted samples in ARM before an auto-trigger.
REQ-005 SHALL have ports pixel_clk (in, 1, sole clock) and sys_rst (in, 1, synchronous, active-high reset).
REQ-006 SHALL have ports frame_start (in, 1, one-cycle pulse at start of vertical blank) and trig_en (in, 1, 1 = level trigger, 0 = free-run).
REQ-007 SHALL have ports s_data (in, 8, ADC sample), s_valid (in, 1) and s_ready (out, 1).
REQ-008 SHALL have ports pixel_xpos (in, 11, current pixel column), rd_addr (out, 11, {bank, index[9:0]}) and rd_valid (out, 1, read address in plot).
REQ-009 SHALL have ports wr_en (out, 1), wr_addr (out, 11, {bank, index[9:0]}) and wr_data (out, 8) as the external dual-port RAM write port.
REQ-010 SHALL have ports disp_bank (out, 1, bank being displayed), busy (out, 1, state != HOLD) and swap_cnt (out, 16, completed swaps, wraps).

Function
REQ-011 SHALL implement states ARM, CAPTURE and HOLD, and SHALL enter ARM on reset.
REQ-012 SHALL accept a sample only on a cycle where s_valid and s_ready are both 1.
REQ-013 SHALL hold s_ready=1 in ARM and CAPTURE, and s_ready=0 in HOLD.
REQ-014 In ARM, SHALL register every accepted sample as prev and SHALL write nothing.
REQ-015 SHALL trigger in ARM on an accepted sample where: trig_en=0; or prev<TRIG_LEVEL and sample>=TRIG_LEVEL; or the arm counter equals ARM_TIMEOUT-1.
REQ-016 On trigger, SHALL write the triggering sample to index 0 that same cycle, set index to 1 and enter CAPTURE.
REQ-017 SHALL clear prev to 8'hFF on entering ARM, so no trigger fires on the first sample after arming.
REQ-018 In CAPTURE, SHALL write each accepted sample to index, then increment index.
REQ-019 In CAPTURE, SHALL enter HOLD after writing index PLOT_W-1.
REQ-020 SHALL drive wr_en combinationally as the accept AND write condition, with wr_addr={~disp_bank, index} and wr_data=s_data.
REQ-021 SHALL never write to the bank equal to disp_bank.
REQ-022 In HOLD, on frame_start=1, SHALL toggle disp_bank, increment swap_cnt, clear index and the arm counter, and enter ARM at the next edge.
REQ-023 SHALL ignore frame_start in ARM and CAPTURE.
REQ-024 SHALL defer the swap to the next frame_start when frame_start coincides with the final CAPTURE write, because the state is not yet HOLD.
REQ-025 SHALL provide read side latency of 1 cycle: rd_valid <= (pixel_xpos >= X0) && (pixel_xpos < X0+PLOT_W).
REQ-026 SHALL register rd_addr <= {disp_bank, pixel_xpos-X0} on the read side, with rd_addr=0 when out of range.
REQ-027 SHALL compute pixel_xpos-X0 in 11 bits and use only the low 10 bits, valid because PLOT_W<=1024.
REQ-028 On a swap, SHALL use the new disp_bank for reads from the cycle after frame_start.

Reset
REQ-029 On sys_rst=1 at a clock edge, SHALL set state=ARM, index=0, arm counter=0, prev=8'hFF, disp_bank=0, swap_cnt=0, rd_valid=0 and rd_addr=0.
REQ-030 During reset, SHALL hold wr_en=0 and s_ready=0.
REQ-031 A reset during CAPTURE or HOLD SHALL abandon the partial trace, and the post-reset bank contents are don't-care.

Verification
REQ-032 SHALL verify free-run fill: reset, trig_en=0, 1000 back-to-back valid samples -> wr_addr 11'h400..11'h7E7 in order; HOLD; s_ready=0; busy=0.
REQ-033 SHALL verify swap: in HOLD, pulse frame_start -> disp_bank=1 and swap_cnt=1 next cycle; next capture writes wr_addr 11'h000 upward.
REQ-034 SHALL verify level trigger: trig_en=1, samples 10,50,127,128,200 -> first write is data 128 at index 0; no write for earlier samples.
REQ-035 SHALL verify auto-trigger: trig_en=1, constant sample 0 -> trigger on sample number 4096, written at index 0.
REQ-036 SHALL verify read mapping: pixel_xpos=139, 140, 1139, 1140 -> rd_valid next cycle 0,1,1,0; rd_addr {disp_bank,0} at 140 and {disp_bank,999} at 1139.
REQ-037 SHALL verify corner cases: frame_start coincident with final write -> no swap until next pulse; sys_rst asserted at index 500 -> ARM, index 0, disp_bank 0, no wr_en during reset.
